// File: rtl/filter_out_decimator.sv
// filter_out_decimator
//   Downstream stage of transposedFilter. Keeps one of every DECIM input samples,
//   buffers kept samples in a FIFO and presents them on a valid/ready output.
//   The filter cannot be stalled, so samples arriving while the FIFO is full are
//   dropped and flagged on a sticky overflow bit.
//   Optional feature macro: DECIM_GAIN_EN (left-shift kept samples by GAIN_SHIFT
//   with signed saturation before they enter the FIFO).
// Ports
//   Clk_i        clock, rising edge
//   Rst_i        asynchronous active-high reset
//   Data_i       input sample (signed, DATA_W bits)
//   DataNd_i     new-data strobe for Data_i
//   DataReady_i  downstream ready
//   Data_o       decimated sample
//   DataValid_o  Data_o holds a sample
//   FifoLevel_o  FIFO occupancy, 0..FIFO_DEPTH (output register not counted)
//   Overflow_o   sticky: a kept sample was dropped
//   OvfClr_i     synchronous clear of Overflow_o
module filter_out_decimator #(
  parameter int unsigned DATA_W      = 18,
  parameter int unsigned DECIM       = 4,
  parameter int unsigned DECIM_PHASE = 0,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned GAIN_SHIFT  = 0
) (
  input  logic                          Clk_i,
  input  logic                          Rst_i,
  input  logic [DATA_W-1:0]             Data_i,
  input  logic                          DataNd_i,
  input  logic                          DataReady_i,
  input  logic                          OvfClr_i,
  output logic [DATA_W-1:0]             Data_o,
  output logic                          DataValid_o,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel_o,
  output logic                          Overflow_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

`ifdef DECIM_GAIN_EN
  localparam bit GAIN_EN = 1'b1;
`else
  localparam bit GAIN_EN = 1'b0;
`endif

  // With the gain disabled the shift collapses to zero and the path is a wire.
  localparam int unsigned SHIFT  = GAIN_EN ? GAIN_SHIFT : 0;
  localparam int unsigned WIDE_W = DATA_W + SHIFT;

  logic [PH_W-1:0]          phase;
  logic                     keep_c;
  logic signed [WIDE_W-1:0] wide_c;
  logic [SHIFT:0]           upper_c;
  logic [DATA_W-1:0]        gained_c;

  logic [DATA_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [LVL_W-1:0]         count;
  logic                     full_c;
  logic                     empty_c;
  logic                     pop_c;
  logic                     wr_c;
  logic                     drop_c;

  // Phase counter: advances only on strobed samples.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      phase <= '0;
    end else if (DataNd_i) begin
      phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
    end
  end

  assign keep_c = DataNd_i && (phase == PH_W'(DECIM_PHASE));

  // Gain with saturation: the bits above the DATA_W-1 sign position must all
  // match, otherwise clamp to the extreme of the input's sign.
  always_comb begin
    wide_c   = WIDE_W'($signed(Data_i)) <<< SHIFT;
    upper_c  = wide_c[WIDE_W-1:DATA_W-1];
    gained_c = wide_c[DATA_W-1:0];
    if (!((&upper_c) || !(|upper_c))) begin
      gained_c = wide_c[WIDE_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // FIFO control: pop refills an empty or departing output register; a write
  // into a full FIFO only succeeds when a pop frees a slot on the same edge.
  assign full_c  = (count == LVL_W'(FIFO_DEPTH));
  assign empty_c = (count == '0);
  assign pop_c   = !empty_c && (!DataValid_o || DataReady_i);
  assign wr_c    = keep_c && (!full_c || pop_c);
  assign drop_c  = keep_c && full_c && !pop_c;

  // Storage array, no reset needed.
  always_ff @(posedge Clk_i) begin
    if (wr_c) begin
      mem[wr_ptr] <= gained_c;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_c)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_c, pop_c})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register; Data_o keeps its last value once drained.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      Data_o      <= '0;
      DataValid_o <= 1'b0;
    end else if (pop_c) begin
      Data_o      <= mem[rd_ptr];
      DataValid_o <= 1'b1;
    end else if (DataValid_o && DataReady_i) begin
      DataValid_o <= 1'b0;
    end
  end

  // Sticky overflow; a drop on the clearing edge takes priority.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      Overflow_o <= 1'b0;
    end else if (drop_c) begin
      Overflow_o <= 1'b1;
    end else if (OvfClr_i) begin
      Overflow_o <= 1'b0;
    end
  end

  assign FifoLevel_o = count;

endmodule

// File: tb/tb_filter_out_decimator.sv
module tb_filter_out_decimator;

  localparam int unsigned W = 18;

`ifdef DECIM_GAIN_EN
  localparam bit GAIN = 1'b1;
`else
  localparam bit GAIN = 1'b0;
`endif
  localparam int unsigned G = GAIN ? 4 : 1;

  localparam logic [W-1:0] G_IN  [4] = '{18'h00100, 18'h08000, 18'h3FFFF, 18'h20000};
  localparam logic [W-1:0] G_EXP [4] = '{18'h00400, 18'h1FFFF, 18'h3FFFC, 18'h20000};

  logic clk;
  logic rst;

  logic [W-1:0] d4_din, d4_dout;
  logic         d4_nd, d4_rdy, d4_clr, d4_vld, d4_ovf;
  logic [3:0]   d4_lvl;

  logic [W-1:0] d1_din, d1_dout;
  logic         d1_nd, d1_rdy, d1_clr, d1_vld, d1_ovf;
  logic [3:0]   d1_lvl;

  logic [W-1:0] d3_din, d3_dout;
  logic         d3_nd, d3_rdy, d3_clr, d3_vld, d3_ovf;
  logic [3:0]   d3_lvl;

  logic [W-1:0] q4 [$];
  logic [W-1:0] q1 [$];
  logic [W-1:0] q3 [$];

  int errors = 0;
  int checks = 0;

  filter_out_decimator #(.DATA_W(W), .DECIM(4), .DECIM_PHASE(0), .FIFO_DEPTH(8), .GAIN_SHIFT(0)) u_d4 (
    .Clk_i(clk), .Rst_i(rst), .Data_i(d4_din), .DataNd_i(d4_nd), .DataReady_i(d4_rdy),
    .OvfClr_i(d4_clr), .Data_o(d4_dout), .DataValid_o(d4_vld), .FifoLevel_o(d4_lvl),
    .Overflow_o(d4_ovf));

  filter_out_decimator #(.DATA_W(W), .DECIM(1), .DECIM_PHASE(0), .FIFO_DEPTH(8), .GAIN_SHIFT(2)) u_d1 (
    .Clk_i(clk), .Rst_i(rst), .Data_i(d1_din), .DataNd_i(d1_nd), .DataReady_i(d1_rdy),
    .OvfClr_i(d1_clr), .Data_o(d1_dout), .DataValid_o(d1_vld), .FifoLevel_o(d1_lvl),
    .Overflow_o(d1_ovf));

  filter_out_decimator #(.DATA_W(W), .DECIM(3), .DECIM_PHASE(2), .FIFO_DEPTH(8), .GAIN_SHIFT(0)) u_d3 (
    .Clk_i(clk), .Rst_i(rst), .Data_i(d3_din), .DataNd_i(d3_nd), .DataReady_i(d3_rdy),
    .OvfClr_i(d3_clr), .Data_o(d3_dout), .DataValid_o(d3_vld), .FifoLevel_o(d3_lvl),
    .Overflow_o(d3_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a transfer happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && d4_vld && d4_rdy) begin
      if (q4.size() == 0) check("d4_unexpected_output", 32'(q4.size()), 32'd1);
      else                check("d4_data", 32'(d4_dout), 32'(q4.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && d1_vld && d1_rdy) begin
      if (q1.size() == 0) check("d1_unexpected_output", 32'(q1.size()), 32'd1);
      else                check("d1_data", 32'(d1_dout), 32'(q1.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && d3_vld && d3_rdy) begin
      if (q3.size() == 0) check("d3_unexpected_output", 32'(q3.size()), 32'd1);
      else                check("d3_data", 32'(d3_dout), 32'(q3.pop_front()));
    end
  end

  initial begin
    logic [31:0] pat;
    int n;

    rst = 1'b1;
    d4_din = '0; d4_nd = 1'b0; d4_rdy = 1'b0; d4_clr = 1'b0;
    d1_din = '0; d1_nd = 1'b0; d1_rdy = 1'b0; d1_clr = 1'b0;
    d3_din = '0; d3_nd = 1'b0; d3_rdy = 1'b0; d3_clr = 1'b0;
    repeat (2) tick();
    check("rst_data",  32'(d1_dout), 32'd0);
    check("rst_valid", 32'(d1_vld),  32'd0);
    check("rst_level", 32'(d1_lvl),  32'd0);
    check("rst_ovf",   32'(d1_ovf),  32'd0);
    rst = 1'b0;
    tick();

    // Impulse through DECIM=4: one 0x1FFFF then zeros every 4th input.
    d4_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d4_nd  = 1'b1;
      d4_din = (i == 0) ? 18'h1FFFF : 18'h0;
      if (i % 4 == 0) q4.push_back(d4_din);
      tick();
      if (i == 0) check("impulse_not_early", 32'(d4_vld), 32'd0);
      if (i == 1) begin
        check("impulse_valid_lat", 32'(d4_vld),  32'd1);
        check("impulse_data_lat",  32'(d4_dout), 32'h1FFFF);
      end
    end
    d4_nd = 1'b0;
    repeat (4) tick();

    // DECIM=3 PHASE=2 with gaps: kept inputs are #2, #5, #8, #11.
    d3_rdy = 1'b1;
    pat = 32'b1011_0010_1110_0101_1001_1101_0111_0011;
    n = 0;
    for (int c = 0; c < 32; c++) begin
      d3_nd  = pat[c] && (n < 12);
      d3_din = 18'(100 + n);
      if (d3_nd) begin
        if (n == 2 || n == 5 || n == 8 || n == 11) q3.push_back(d3_din);
        n++;
      end
      tick();
    end
    d3_nd = 1'b0;
    repeat (4) tick();

    // Stall and overflow on DECIM=1; the drop edge also asserts clear (set wins).
    d1_rdy = 1'b0;
    for (int v = 1; v <= 10; v++) begin
      d1_nd  = 1'b1;
      d1_din = 18'(v);
      d1_clr = (v == 10);
      if (v <= 9) q1.push_back(18'(v * G));
      tick();
      if (v == 9) check("ovf_before_drop", 32'(d1_ovf), 32'd0);
    end
    d1_nd = 1'b0; d1_clr = 1'b0;
    check("stall_ovf_set_wins", 32'(d1_ovf),  32'd1);
    check("stall_level_full",   32'(d1_lvl),  32'd8);
    check("stall_valid",        32'(d1_vld),  32'd1);
    check("stall_data_first",   32'(d1_dout), 32'(1 * G));
    repeat (3) tick();
    check("stall_ovf_sticky",   32'(d1_ovf),  32'd1);
    check("stall_data_hold",    32'(d1_dout), 32'(1 * G));
    d1_clr = 1'b1;
    tick();
    d1_clr = 1'b0;
    check("ovf_cleared",        32'(d1_ovf),  32'd0);

    // Full FIFO with transfer and new kept sample on the same edge.
    d1_rdy = 1'b1;
    d1_nd  = 1'b1;
    d1_din = 18'd11;
    q1.push_back(18'(11 * G));
    tick();
    d1_nd = 1'b0;
    check("simul_level", 32'(d1_lvl), 32'd8);
    check("simul_no_ovf", 32'(d1_ovf), 32'd0);
    repeat (12) tick();
    check("drain_level", 32'(d1_lvl),  32'd0);
    check("drain_valid", 32'(d1_vld),  32'd0);
    check("drain_hold",  32'(d1_dout), 32'(11 * G));

    // Gain vectors (pass-through when the gain feature is not built in).
    for (int i = 0; i < 4; i++) begin
      d1_nd  = 1'b1;
      d1_din = G_IN[i];
      q1.push_back(GAIN ? G_EXP[i] : G_IN[i]);
      tick();
    end
    d1_nd = 1'b0;
    repeat (4) tick();

    // Mid-stream reset: d1 at level 5, d4 left at phase 2 with a pending sample.
    d1_rdy = 1'b0;
    d4_rdy = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      d1_nd  = 1'b1;
      d1_din = 18'(v);
      d4_nd  = (v <= 2);
      d4_din = 18'(v + 7);
      tick();
    end
    d1_nd = 1'b0; d4_nd = 1'b0;
    check("pre_rst_level", 32'(d1_lvl), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid",    32'(d1_vld), 32'd0);
    check("mid_rst_level",    32'(d1_lvl), 32'd0);
    check("mid_rst_ovf",      32'(d1_ovf), 32'd0);
    check("mid_rst_d4_valid", 32'(d4_vld), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // After reset the first kept input is the first strobed one.
    d4_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d4_nd  = 1'b1;
      d4_din = 18'(200 + i);
      if (i % 4 == 0) q4.push_back(d4_din);
      tick();
    end
    d4_nd = 1'b0;
    repeat (10) tick();

    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
